// File: rtl/uart_rx_buffer.sv
// Receive byte FIFO between the UART receiver and the datapath's UART read port.
// Latency: a pushed byte sets DataOutValid after one edge; a pop registers the byte on DataOut after one edge.
// Backpressure: rx_ready drops when full; a byte offered while full is dropped and sets sticky overflow.
module uart_rx_buffer #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            DataOut,
  output logic                  DataOutValid,
  input  logic                  DataOutReady,
  input  logic                  Stall,
  input  logic                  flush,
  input  logic                  clear_overflow,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Status comes only from the registered count, so rx_ready never depends on rx_valid.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign rx_ready     = ~full;
  assign DataOutValid = ~empty;

  // Flush wins over both transfers in the same cycle, so both are discarded here.
  assign push = rx_valid & ~full & ~flush;
  assign pop  = DataOutReady & ~Stall & ~empty & ~flush;

  // Byte storage; contents are never cleared, only the pointers are.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wp] <= rx_data;
    end
  end

  // Pointers, occupancy and the registered read byte.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      DataOut <= 8'h00;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp      <= rp + 1'b1;
        DataOut <= mem[rp];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a byte offered while full; a coincident clear loses to the set.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (rx_valid & full) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed steps plus random traffic
// compared against a queue-based reference model of the buffer.
// Outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_buffer;

  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    DataOut;
  logic          DataOutValid;
  logic          DataOutReady;
  logic          Stall;
  logic          flush;
  logic          clear_overflow;
  logic [DL:0]   count;
  logic          overflow;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_ovf;

  uart_rx_buffer #(.DEPTH_LOG2(DL)) dut (
    .CLK            (CLK),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .DataOut        (DataOut),
    .DataOutValid   (DataOutValid),
    .DataOutReady   (DataOutReady),
    .Stall          (Stall),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Compare every output against the model.
  task automatic chk_model(input string tag);
    chk({tag, ".DataOut"},      32'(DataOut),      32'(m_dout));
    chk({tag, ".DataOutValid"}, 32'(DataOutValid), 32'(mq.size() != 0));
    chk({tag, ".count"},        32'(count),        32'(mq.size()));
    chk({tag, ".rx_ready"},     32'(rx_ready),     32'(mq.size() != DEPTH));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
  endtask

  // One clock cycle with the given inputs; the model advances at the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rd,
                     input logic st, input logic fl, input logic clr);
    bit was_full, was_empty;
    rx_valid = v; rx_data = d; DataOutReady = rd; Stall = st;
    flush = fl; clear_overflow = clr;
    @(posedge CLK);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (v && was_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rd && !st && !was_empty) m_dout = mq.pop_front();
      if (v && !was_full) mq.push_back(d);
    end
    #1;
    rx_valid = 1'b0; DataOutReady = 1'b0; Stall = 1'b0;
    flush = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; DataOutReady = 1'b0;
    Stall = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
    model_reset();
    #12;
    chk_model("reset");
    chk("reset.DataOut_const", 32'(DataOut), 32'h00);
    @(posedge CLK); #1;
    reset_n = 1'b1;

    // Basic push then pop of three bytes.
    push(8'h41); push(8'h42); push(8'h43);
    chk("push3.count", 32'(count), 32'd3);
    chk("push3.valid", 32'(DataOutValid), 32'd1);
    pop(); chk("pop1", 32'(DataOut), 32'h41);
    pop(); chk("pop2", 32'(DataOut), 32'h42);
    pop(); chk("pop3", 32'(DataOut), 32'h43);
    chk_model("drain3");

    // Fill, overflow, drain, clear.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("full.rx_ready", 32'(rx_ready), 32'd0);
    chk("full.count", 32'(count), 32'(DEPTH));
    push(8'hFF);
    chk("ovf.set", 32'(overflow), 32'd1);
    chk_model("ovf");
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      chk("drain.byte", 32'(DataOut), 32'(i));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf.clear", 32'(overflow), 32'd0);

    // Set and clear together: set wins.
    for (int i = 0; i < DEPTH; i++) push(8'hA0 + 8'(i));
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf.set_wins", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush.keeps_ovf", 32'(overflow), 32'd1);
    chk_model("flush_full");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Wrap-around: hold 4 entries with simultaneous push/pop.
    d = 8'h80;
    for (int i = 0; i < 4; i++) begin push(d); d++; end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
      d++;
      chk("wrap.count", 32'(count), 32'd4);
      chk("wrap.byte", 32'(DataOut), 32'(8'h80 + 8'(i)));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stall holds REUART off.
    push(8'h10); push(8'h11);
    d = DataOut;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stall.count", 32'(count), 32'd2);
      chk("stall.dout", 32'(DataOut), 32'(d));
    end
    pop();
    chk("unstall.dout", 32'(DataOut), 32'h10);
    chk("unstall.count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with push and pop in the same cycle.
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    d = DataOut;
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("flushpp.count", 32'(count), 32'd0);
    chk("flushpp.valid", 32'(DataOutValid), 32'd0);
    chk("flushpp.dout", 32'(DataOut), 32'(d));
    chk_model("flushpp");
    push(8'h5A); pop();
    chk("after_flush", 32'(DataOut), 32'h5A);

    // Empty pop coinciding with a push.
    push(8'h33); pop();
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("emptypop.dout", 32'(DataOut), 32'h33);
    chk("emptypop.count", 32'(count), 32'd1);
    pop();
    chk("emptypop.next", 32'(DataOut), 32'h77);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
      chk_model("rand");
    end

    // Asynchronous reset in the middle of a burst.
    push(8'hC1); push(8'hC2); pop();
    rx_valid = 1'b1; rx_data = 8'hC3; DataOutReady = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_model("async_reset");
    rx_valid = 1'b0; DataOutReady = 1'b0;
    @(posedge CLK); #1;
    reset_n = 1'b1;
    push(8'hD4); pop();
    chk("post_reset", 32'(DataOut), 32'hD4);
    chk_model("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
